// File: rtl/inst_loader_if.sv
// inst_loader_if: instruction word stream into the loader and the
// instruction-memory write port out of it.
interface inst_loader_if #(
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_SIZE-1:0] in_data;
   logic                 in_last;
   logic                 mem_write_enable;
   logic [ADDR_SIZE-1:0] mem_write_addr;
   logic [DATA_SIZE-1:0] mem_write_data;
   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, mem_write_enable, mem_write_addr, mem_write_data
   );
   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, mem_write_enable, mem_write_addr, mem_write_data
   );
endinterface

// File: rtl/inst_loader.sv
// inst_loader: streams a program into instruction memory, pads with NOP, then runs the core.
// Define INST_LOADER_CHECKSUM_EN to require an XOR checksum word after the in_last word.
module inst_loader #(
   parameter int ADDR_SIZE = 5,
   parameter int DATA_SIZE = 32,
   parameter int MEM_LEN = 32,
   parameter logic [DATA_SIZE-1:0] FILL_WORD = 32'h00000013
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   inst_loader_if.slave       bus,
   output logic               proc_run,
   input  logic               proc_done,
   output logic [ADDR_SIZE:0] loaded_count,
   output logic               error,
   output logic               busy
);
   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] LOAD  = 3'd1;
   localparam logic [2:0] DRAIN = 3'd2;
   localparam logic [2:0] FILL  = 3'd3;
   localparam logic [2:0] RUN   = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;
`ifdef INST_LOADER_CHECKSUM_EN
   localparam logic [2:0] CHECK = 3'd6;
`endif
   localparam logic [ADDR_SIZE-1:0] LAST = ADDR_SIZE'(MEM_LEN - 1);
   localparam logic [ADDR_SIZE:0]   FULL = (ADDR_SIZE + 1)'(MEM_LEN);
   logic [2:0]           state, state_n;
   logic [ADDR_SIZE-1:0] addr;
   logic                 xfer;
   logic                 launch;
`ifdef INST_LOADER_CHECKSUM_EN
   logic [DATA_SIZE-1:0] csum;
   assign bus.in_ready = state == LOAD || state == DRAIN || state == CHECK;
`else
   assign bus.in_ready = state == LOAD || state == DRAIN;
`endif
   assign xfer   = bus.in_valid & bus.in_ready;
   assign busy   = state != IDLE && state != DONE;
   assign launch = (state == IDLE || state == DONE) && start;
   always_comb begin
      state_n = state;
      case (state)
         IDLE, DONE: state_n = start ? LOAD : state;
         LOAD:
            if (xfer && bus.in_last)
`ifdef INST_LOADER_CHECKSUM_EN
               state_n = CHECK;
`else
               state_n = addr == LAST ? RUN : FILL;
`endif
            else if (xfer && addr == LAST)
               state_n = DRAIN;
         DRAIN: state_n = xfer && bus.in_last ? DONE : DRAIN;
`ifdef INST_LOADER_CHECKSUM_EN
         // loaded_count already includes the in_last word, so FULL means nothing to pad
         CHECK:
            if (xfer)
               state_n = bus.in_data != csum ? DONE : loaded_count == FULL ? RUN : FILL;
`endif
         FILL: state_n = addr == LAST ? RUN : FILL;
         RUN: state_n = proc_done ? DONE : RUN;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         addr <= '0;
         loaded_count <= '0;
         error <= 1'b0;
         proc_run <= 1'b0;
         bus.mem_write_enable <= 1'b0;
         bus.mem_write_addr <= '0;
         bus.mem_write_data <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
         csum <= '0;
`endif
      end else begin
         state <= state_n;
         // registered so the core starts one cycle after the last write lands
         proc_run <= state == RUN && !proc_done;
         bus.mem_write_enable <= (state == LOAD && xfer) || state == FILL;
         if ((state == LOAD && xfer) || state == FILL) begin
            bus.mem_write_addr <= addr;
            bus.mem_write_data <= state == FILL ? FILL_WORD : bus.in_data;
            addr <= addr == LAST ? addr : addr + 1'b1;
         end
         if (state == LOAD && xfer)
            loaded_count <= loaded_count == FULL ? FULL : loaded_count + 1'b1;
         if (state == DRAIN && xfer)
            error <= 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
         if (state == LOAD && xfer)
            csum <= csum ^ bus.in_data;
         if (state == CHECK && xfer && bus.in_data != csum)
            error <= 1'b1;
         if (launch)
            csum <= '0;
`endif
         if (launch) begin
            addr <= '0;
            loaded_count <= '0;
            error <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_inst_loader.sv
// tb_inst_loader: random programs against a memory-image model of the loader.
module tb_inst_loader;
   logic clk = 1'b0;
   logic rst, start, proc_done, proc_run, error, busy;
   logic [5:0] loaded_count;
   logic [31:0] wbuf [0:63];
   logic [31:0] tbmem [0:31];
   int checks = 0, errors = 0, cyc = 0, wr_cnt = 0, last_wr_cyc = 0, rise_cyc = 0;
   bit run_seen = 0;
   inst_loader_if #(.ADDR_SIZE(5), .DATA_SIZE(32)) bus ();
   inst_loader dut (
      .clk(clk), .rst(rst), .start(start), .bus(bus), .proc_run(proc_run),
      .proc_done(proc_done), .loaded_count(loaded_count), .error(error), .busy(busy)
   );
   always #5 clk = ~clk;
   // observe the memory write port and the first rise of proc_run
   always @(negedge clk) begin
      cyc++;
      if (bus.mem_write_enable === 1'b1) begin
         tbmem[bus.mem_write_addr] = bus.mem_write_data;
         wr_cnt++;
         last_wr_cyc = cyc;
      end
      if (proc_run === 1'b1 && !run_seen) begin
         run_seen = 1;
         rise_cyc = cyc;
      end
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask
   task automatic feed(input int total, input int last_idx);
      int idx = 0, guard = 0;
      logic v, r;
      while (idx < total && guard < 2000) begin
         @(negedge clk);
         v = $urandom_range(3) != 0;
         bus.in_valid = v;
         bus.in_data = wbuf[idx];
         bus.in_last = idx == last_idx;
         r = bus.in_ready;
         @(posedge clk);
         if (v && r) idx++;
         guard++;
      end
      chk("feed_done", idx, total);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask
   task automatic run_prog(input int n, input bit good);
      int m, total, t;
      logic [31:0] cs, img;
      bit exp_run, exp_fill;
      m = n > 32 ? 32 : n;
      cs = '0;
      for (int i = 0; i < m; i++) cs ^= wbuf[i];
      total = n;
`ifdef INST_LOADER_CHECKSUM_EN
      if (n <= 32) begin
         wbuf[n] = good ? cs : cs ^ 32'h7;
         total = n + 1;
      end
`endif
      exp_run = n <= 32 && good;
      exp_fill = exp_run && n < 32;
      for (int i = 0; i < 32; i++) tbmem[i] = 32'hDEADBEEF;
      wr_cnt = 0;
      run_seen = 0;
      pulse_start();
      feed(total, n - 1);
      bus.in_valid = 1'b1;
      bus.in_data = $urandom;
      t = 0;
      if (exp_run) begin
         while (!run_seen && t < 200) begin
            @(negedge clk);
            t++;
         end
         chk("run_rise", 32'(run_seen), 1);
         chk("run_delay", rise_cyc - last_wr_cyc, 1);
         chk("busy_run", busy, 1);
      end else begin
         repeat (40) @(negedge clk);
         chk("no_run", 32'(run_seen), 0);
         chk("busy_done", busy, 0);
      end
      bus.in_valid = 1'b0;
      chk("loaded_count", loaded_count, m);
      chk("error", error, !exp_run);
      chk("writes", wr_cnt, exp_fill ? 32 : m);
      for (int i = 0; i < 32; i++) begin
         img = i < m ? wbuf[i] : exp_fill ? 32'h00000013 : 32'hDEADBEEF;
         chk($sformatf("mem[%0d]", i), tbmem[i], img);
      end
   endtask
   task automatic end_run();
      repeat ($urandom_range(4)) @(negedge clk);
      proc_done = 1'b1;
      @(negedge clk) proc_done = 1'b0;
      chk("run_fall", proc_run, 0);
      chk("busy_fall", busy, 0);
   endtask
   task automatic rand_words();
      for (int i = 0; i < 64; i++) wbuf[i] = $urandom;
   endtask
   initial begin
      int n;
      rst = 1'b1; start = 1'b0; proc_done = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_we", bus.mem_write_enable, 0);
      chk("rst_addr", bus.mem_write_addr, 0);
      chk("rst_data", bus.mem_write_data, 0);
      chk("rst_run", proc_run, 0);
      chk("rst_count", loaded_count, 0);
      chk("rst_error", error, 0);
      chk("rst_busy", busy, 0);
      rand_words();
      pulse_start();
      feed(5, -1);
      chk("mid_load_busy", busy, 1);
      chk("mid_load_count", loaded_count, 5);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_ready", bus.in_ready, 0);
      chk("abort_we", bus.mem_write_enable, 0);
      chk("abort_run", proc_run, 0);
      chk("abort_count", loaded_count, 0);
      chk("abort_busy", busy, 0);
      wbuf[0] = 32'h00500093; wbuf[1] = 32'h00600113; wbuf[2] = 32'h002081B3;
      run_prog(3, 1);
      pulse_start();
      chk("start_ignored_busy", busy, 1);
      chk("start_ignored_run", proc_run, 1);
      end_run();
      rand_words();
      run_prog(1, 1);
      end_run();
      rand_words();
      run_prog(32, 1);
      end_run();
      rand_words();
      run_prog(34, 1);
      rand_words();
      run_prog(1, 1);
      end_run();
      rand_words();
      run_prog($urandom_range(1, 31), 1);
      @(negedge clk) begin proc_done = 1'b1; start = 1'b1; end
      @(negedge clk) begin proc_done = 1'b0; start = 1'b0; end
      repeat (2) @(negedge clk);
      chk("coinc_busy", busy, 0);
      chk("coinc_ready", bus.in_ready, 0);
      chk("coinc_run", proc_run, 0);
      for (int k = 0; k < 6; k++) begin
         rand_words();
         n = $urandom_range(1, 36);
         run_prog(n, 1);
         if (n <= 32) end_run();
      end
`ifdef INST_LOADER_CHECKSUM_EN
      wbuf[0] = 32'h1; wbuf[1] = 32'h2;
      run_prog(2, 1);
      end_run();
      wbuf[0] = 32'h1; wbuf[1] = 32'h2;
      run_prog(2, 0);
      for (int k = 0; k < 4; k++) begin
         rand_words();
         n = $urandom_range(1, 32);
         run_prog(n, k[0]);
         if (k[0]) end_run();
      end
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
